// File: rtl/muldiv_seq_if.sv
// Multiply/divide request/response bundle between the MIPS datapath (master)
// and the iterative HI/LO unit (slave).
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] hi;

   modport master (
      output start, op, a, b,
      input  busy, done, lo, hi
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, lo, hi
   );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 shift-add multiplier / restoring divider producing the MIPS HI/LO pair,
// one iteration per cycle, XLEN iterations per operation.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   muldiv_seq_if.slave bus,
   output logic [1:0]  dbg_state
);
   // Handshake: start (with op/a/b) is accepted only in IDLE (busy=0, done=0);
   // anything else is dropped. done is a one-cycle pulse; lo/hi are valid in that
   // cycle and hold until the next done. There is no backpressure on the result.

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q;
   logic            div_q, neg_q, rem_neg_q, dz_q;
   logic [XLEN-1:0] m_q, acc_hi_q, acc_lo_q, lo_q, hi_q;

   logic            in_signed, sign_a, sign_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, rem_sh, trial;
   logic [XLEN-1:0] acc_hi_d, acc_lo_d, lo_fix, hi_fix;
   logic [2*XLEN-1:0] prod_neg;
   logic            last_iter;

   assign in_signed = ~bus.op[0];
   assign sign_a    = in_signed & bus.a[XLEN-1];
   assign sign_b    = in_signed & bus.b[XLEN-1];
   assign mag_a     = sign_a ? -bus.a : bus.a;
   assign mag_b     = sign_b ? -bus.b : bus.b;
   assign last_iter = (count_q == CW'(XLEN-1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CALC;
         CALC:    if (last_iter) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // m_q is the multiplicand for mult and the divisor for div; acc_lo holds the
   // multiplier / dividend bits being consumed.
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
      rem_sh   = {acc_hi_q, acc_lo_q[XLEN-1]};
      trial    = rem_sh - {1'b0, m_q};
      acc_hi_d = mul_sum[XLEN:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
      if (div_q) begin
         if (!trial[XLEN]) begin
            acc_hi_d = trial[XLEN-1:0];
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
         end else begin
            acc_hi_d = rem_sh[XLEN-1:0];
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
         end
      end
      prod_neg = -{acc_hi_d, acc_lo_d};
      lo_fix   = neg_q ? prod_neg[XLEN-1:0]      : acc_lo_d;
      hi_fix   = neg_q ? prod_neg[2*XLEN-1:XLEN] : acc_hi_d;
      // With a zero divisor every trial succeeds: quotient is all ones and the
      // remainder is |a|, which the dividend-sign fix turns back into raw a.
      if (div_q) begin
         lo_fix = dz_q ? {XLEN{1'b1}} : (neg_q ? -acc_lo_d : acc_lo_d);
         hi_fix = rem_neg_q ? -acc_hi_d : acc_hi_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         m_q       <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (bus.start) begin
               div_q     <= bus.op[1];
               neg_q     <= sign_a ^ sign_b;
               rem_neg_q <= sign_a;
               dz_q      <= (bus.b == '0);
               m_q       <= bus.op[1] ? mag_b : mag_a;
               acc_hi_q  <= '0;
               acc_lo_q  <= bus.op[1] ? mag_a : mag_b;
               count_q   <= '0;
            end
            CALC: begin
               acc_hi_q <= acc_hi_d;
               acc_lo_q <= acc_lo_d;
               count_q  <= count_q + 1'b1;
               if (last_iter) begin
                  lo_q <= lo_fix;
                  hi_q <= hi_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = (state_q == CALC);
   assign bus.done  = (state_q == DONE);
   assign bus.lo    = lo_q;
   assign bus.hi    = hi_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed MIPS HI/LO cases plus random operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_seq;
  localparam int XLEN = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [2*XLEN-1:0] exp_q[$];
  logic [2*XLEN-1:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // reference model: {hi, lo} from MIPS mult/multu/div/divu semantics
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin pu = {32'b0, a} * {32'b0, b}; return pu; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // driver: called just after a rising edge (cycle 0); returns in cycle XLEN+2.
  // noise=1 pulses start with junk operands in cycles 5 and XLEN+1.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [63:0] res;
    exp_q.push_back(ref_model(op, a, b));
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    check("busy_c0", bus.busy, 1'b0);
    @(posedge clk); #1;
    for (int c = 1; c <= XLEN + 1; c++) begin
      bus.start = noise && (c == 5 || c == XLEN + 1);
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = $urandom;
      bus.b     = $urandom;
      @(negedge clk);
      check("busy", bus.busy, c <= XLEN);
      check("done", bus.done, c == XLEN + 1);
      if (c <= XLEN) check("hold", {bus.hi, bus.lo}, last_res);
      if (c == XLEN + 1) begin
        res = exp_q.pop_front();
        check("result", {bus.hi, bus.lo}, res);
        last_res = res;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  // launch, then assert reset (with a coincident start) in cycle rst_cyc
  task automatic reset_mid(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int rst_cyc);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    for (int c = 1; c <= rst_cyc; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    last_res  = '0;
    for (int c = rst_cyc + 1; c <= 40; c++) begin
      @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_lohi", {bus.hi, bus.lo}, 64'd0);
      check("rst_state", dbg_state, 2'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_lohi", {bus.hi, bus.lo}, 64'd0);
    check("reset_state", dbg_state, 2'd0);
    @(posedge clk); #1;

    // directed cases
    run_op(2'b00, 32'd7,          32'hFFFF_FFFD, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9,  32'd2,         1'b0);
    run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'h0000_1234,  32'd0,         1'b0);
    run_op(2'b10, 32'h0000_1234,  32'd0,         1'b0);
    run_op(2'b10, 32'h8000_1234,  32'd0,         1'b0);
    run_op(2'b11, 32'hFFFF_FFFF,  32'd7,         1'b0);
    run_op(2'b00, 32'h8000_0000,  32'h8000_0000, 1'b0);

    // ignored starts, then back-to-back issue in cycle XLEN+2
    run_op(2'b01, 32'd3, 32'd5, 1'b1);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 1'b0);

    // reset mid-operation, then a clean operation
    reset_mid(2'b01, 32'd1234, 32'd5678, 10);
    run_op(2'b00, 32'hFFFF_FF00, 32'd77, 1'b0);

    // random operations
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0));
    end

    // results hold through IDLE
    repeat (3) begin
      @(negedge clk);
      check("idle_hold", {bus.hi, bus.lo}, last_res);
      check("idle_done", bus.done, 1'b0);
      @(posedge clk); #1;
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative 32-bit multiply/divide unit that produces the HI/LO pair for the special-register file of the MIPS datapath. It replaces the single-cycle combinational product path with a radix-2 shift-add / restoring-divide engine, so the critical path no longer includes a 32x32 multiplier. The datapath launches an operation with a one-cycle `start` and receives a one-cycle `done` with `lo`/`hi`. `done` connects directly to the special-register write enable; `lo` drives write data 0 and `hi` drives write data 1.

## Interface
- `XLEN`, 32: operand width; the iteration count equals XLEN.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launch request; sampled only in IDLE.
- `op` in 2: operation, sampled with `start`. 00 = mult (signed), 01 = multu, 10 = div (signed), 11 = divu.
- `a` in XLEN: rs operand (multiplicand / dividend); sampled with `start`.
- `b` in XLEN: rt operand (multiplier / divisor); sampled with `start`.
- `busy` out 1: high while iterating (CALC).
- `done` out 1: one-cycle pulse; result valid; use as the HI/LO write enable.
- `lo` out XLEN: product[31:0] or quotient.
- `hi` out XLEN: product[63:32] or remainder.

## Operation
- States:
  - IDLE: `busy` = 0, `done` = 0.
    - If `start` = 1, latch `op`, |a|, |b|, the sign flags and the divide-by-zero flag, clear `count`, and go to CALC.
  - CALC: `busy` = 1. Performs one iteration per cycle while `count` runs 0..XLEN-1.
    - On the edge where `count` = XLEN-1, apply the sign fix, register `lo`/`hi`, and go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- Signedness:
  - Signed ops iterate on magnitudes; unsigned ops use the raw operands.
  - mult: negate the 64-bit product (two's complement) when sign(a) XOR sign(b).
  - div: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
- Multiply:
  - 64-bit accumulator {hi_acc, lo_acc}, initialised to {0, |b|}.
  - Each cycle: if lo_acc[0], add |a| into hi_acc with carry out; then shift the 65-bit {carry, hi_acc, lo_acc} right by 1.
- Divide (restoring):
  - Each cycle: shift {rem, quo} left by 1, trial-subtract |b| from rem, and keep the result if it is non-negative.
  - The quotient bit is 1 on success, else 0.
- Divide by zero (b = 0, both div and divu): `lo` = 0xFFFFFFFF, `hi` = a (raw).
  - Still takes the full latency; no exception.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): `lo` = 0x80000000, `hi` = 0. No trap.
- `start` in CALC or DONE is ignored; there is no queueing.
- `lo`/`hi` hold their last result until the next DONE, including through IDLE.
- Operand changes after the `start` edge have no effect.

## Timing
- Cycle 0: `start` = 1 in IDLE.
- Cycles 1..XLEN: `busy` = 1.
- Cycle XLEN+1: `done` = 1 and `lo`/`hi` are valid (latency 33 cycles for XLEN = 32). `busy` = 0 in this cycle.
- Cycle XLEN+2: back in IDLE; `start` is accepted in this cycle. Minimum issue interval is XLEN+2 cycles.
- Reset values: state IDLE, `busy` 0, `done` 0, `lo` 0, `hi` 0, `count` 0.
- Reset asserted mid-CALC or in DONE:
  - On that edge the FSM returns to IDLE and `lo`/`hi` go to 0; no `done` is emitted.
  - `start` coincident with `reset` is ignored.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Signed mult: `op`=00, `a`=7, `b`=0xFFFFFFFD (-3), `start` at cycle 0.
  - Required: `busy` in cycles 1-32; `done` in cycle 33 only; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Unsigned mult: `op`=01, `a`=`b`=0xFFFFFFFF.
  - Required: `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - Repeat with `op`=00: `hi`=0, `lo`=1.
- Signed divide: `op`=10, `a`=0xFFFFFFF9 (-7), `b`=2.
  - Required: `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1).
  - Also `a`=0x80000000, `b`=0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero: `op`=11 and `op`=10 with `a`=0x00001234, `b`=0.
  - Required: `lo`=0xFFFFFFFF, `hi`=0x00001234, `done` still at cycle 33.
- Ignored start: launch multu 3*5, then pulse `start` with new operands at cycles 5 and 33.
  - Required: a single `done` at cycle 33 with `lo`=15, `hi`=0.
  - A new `start` at cycle 34 is accepted, with `done` at cycle 67.
- Reset mid-op: launch an op, assert `reset` in cycle 10.
  - Required: from cycle 11, `busy`=0, `done`=0, `lo`=`hi`=0.
  - No `done` through cycle 40.
  - A subsequent `start` produces a correct result 33 cycles later.
